stack_op_sequencer: RTL and testbench

// Upstream driver of stack32: takes one stack-level operation from the decode stage, runs the pop/compute/push traffic, returns the result.

---
 rtl/bali_stack_pkg.sv | 45 ++++
 rtl/stack_op_alu.sv | 29 ++
 rtl/stack_op_sequencer.sv | 134 +++++++++++++
 tb/tb_stack_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bali_stack_pkg.sv
// bali_stack_pkg: opcode/state types, error codes and per-op stack traffic counts
package bali_stack_pkg;

    typedef enum logic [3:0] {
        OP_PUSH_IMM = 4'h0,
        OP_POP      = 4'h1,
        OP_DUP      = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUB      = 4'h4,
        OP_MUL      = 4'h5,
        OP_AND      = 4'h6,
        OP_OR       = 4'h7,
        OP_XOR      = 4'h8,
        OP_SHL      = 4'h9,
        OP_SHR      = 4'hA,
        OP_USHR     = 4'hB,
        OP_NEG      = 4'hC
    } stack_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP_B,
        S_WAIT_B,
        S_POP_A,
        S_WAIT_A,
        S_EXEC,
        S_PUSH,
        S_WAIT_P,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    function automatic logic [1:0] op_pops(input stack_op_e op);
        return (op == OP_PUSH_IMM) ? 2'd0 : (op inside {OP_POP, OP_DUP, OP_NEG}) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:0] op_pushes(input stack_op_e op);
        return (op == OP_POP) ? 2'd0 : (op == OP_DUP) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/stack_op_alu.sv
// stack_op_alu: combinational result of one stack op from value1 (deeper) and value2 (top)
module stack_op_alu
    import bali_stack_pkg::*;
(
    input  stack_op_e   op_i,
    input  logic [31:0] value1_i,
    input  logic [31:0] value2_i,
    output logic [31:0] result_o
);

    // value2 doubles as the immediate for PUSH_IMM and the passthrough for POP/DUP
    always_comb begin
        result_o = value2_i;
        case (op_i)
            OP_ADD:  result_o = value1_i + value2_i;
            OP_SUB:  result_o = value1_i - value2_i;
            OP_MUL:  result_o = value1_i * value2_i;
            OP_AND:  result_o = value1_i & value2_i;
            OP_OR:   result_o = value1_i | value2_i;
            OP_XOR:  result_o = value1_i ^ value2_i;
            OP_SHL:  result_o = value1_i << value2_i[4:0];
            OP_SHR:  result_o = $signed(value1_i) >>> value2_i[4:0];
            OP_USHR: result_o = value1_i >> value2_i[4:0];
            OP_NEG:  result_o = 32'd0 - value2_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: runs pop/compute/push traffic on stack32 for one stack-level op
module stack_op_sequencer
    import bali_stack_pkg::*;
#(
    parameter int STACK_DEPTH    = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [3:0]                       op_code,
    input  logic [31:0]                      op_imm,
    output logic [31:0]                      result,
    output logic                             result_valid,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stk_push,
    output logic                             stk_trigger,
    output logic [31:0]                      stk_write_value,
    input  logic [31:0]                      stk_read_value,
    input  logic                             stk_done
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    stack_op_e     op_q, op_in;
    logic [31:0]   val_a_q, val_b_q, push_val_q, result_q, alu_res;
    logic [DW-1:0] depth_q;
    logic [TW-1:0] tmo_q;
    logic          push_left_q, result_valid_q, error_q;
    logic [1:0]    err_code_q, acc_code;
    logic          accept, in_wait, tmo_hit, pop_done, push_done;

    assign op_in     = stack_op_e'(op_code);
    assign accept    = op_valid && state_q == S_IDLE;
    assign in_wait   = state_q inside {S_WAIT_B, S_WAIT_A, S_WAIT_P};
    assign tmo_hit   = in_wait && !stk_done && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign pop_done  = stk_done && state_q inside {S_WAIT_B, S_WAIT_A};
    assign push_done = stk_done && state_q == S_WAIT_P;

    assign acc_code = (op_code > 4'hC) ? ERR_TIMEOUT :
                      (int'(depth_q) < int'(op_pops(op_in))) ? ERR_UNDERFLOW :
                      (int'(depth_q) - int'(op_pops(op_in)) + int'(op_pushes(op_in)) > STACK_DEPTH) ? ERR_OVERFLOW :
                      ERR_NONE;

    stack_op_alu u_alu (
        .op_i     (op_q),
        .value1_i (val_a_q),
        .value2_i (val_b_q),
        .result_o (alu_res)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: skip pops the op does not need, repeat the push for DUP, bail out on timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && acc_code == ERR_NONE)
                          state_d = (op_pops(op_in) == 2'd0) ? S_EXEC : S_POP_B;
            S_POP_B:  state_d = S_WAIT_B;
            S_WAIT_B: state_d = tmo_hit ? S_IDLE : !stk_done ? S_WAIT_B :
                                (op_pops(op_q) == 2'd2) ? S_POP_A : S_EXEC;
            S_POP_A:  state_d = S_WAIT_A;
            S_WAIT_A: state_d = tmo_hit ? S_IDLE : stk_done ? S_EXEC : S_WAIT_A;
            S_EXEC:   state_d = (op_pushes(op_q) == 2'd0) ? S_DONE : S_PUSH;
            S_PUSH:   state_d = S_WAIT_P;
            S_WAIT_P: state_d = tmo_hit ? S_IDLE : !stk_done ? S_WAIT_P :
                                push_left_q ? S_PUSH : S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Stack-side strobes decoded from state; write data stays stable until the push completes
    always_comb begin
        op_ready        = state_q == S_IDLE;
        stk_trigger     = state_q inside {S_POP_B, S_POP_A, S_PUSH};
        stk_push        = state_q == S_PUSH;
        stk_write_value = (state_q inside {S_PUSH, S_WAIT_P}) ? push_val_q : 32'd0;
    end

    // Operands, shadow depth, timeout counter and completion/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= OP_PUSH_IMM;
            val_a_q        <= '0;
            val_b_q        <= '0;
            push_val_q     <= '0;
            result_q       <= '0;
            depth_q        <= '0;
            tmo_q          <= '0;
            push_left_q    <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            result_valid_q <= state_q == S_DONE;
            error_q        <= (accept && acc_code != ERR_NONE) || tmo_hit;
            tmo_q          <= in_wait ? tmo_q + 1'b1 : '0;
            if (accept) begin
                op_q    <= op_in;
                val_b_q <= op_imm;
            end
            if (accept && acc_code != ERR_NONE) err_code_q <= acc_code;
            if (tmo_hit) err_code_q <= ERR_TIMEOUT;
            if (state_q == S_WAIT_B && stk_done) val_b_q <= stk_read_value;
            if (state_q == S_WAIT_A && stk_done) val_a_q <= stk_read_value;
            if (pop_done) depth_q <= depth_q - 1'b1;
            else if (push_done) depth_q <= depth_q + 1'b1;
            if (state_q == S_EXEC) begin
                push_val_q  <= alu_res;
                push_left_q <= op_q == OP_DUP;
            end
            if (push_done) push_left_q <= 1'b0;
            if (state_q == S_DONE) result_q <= push_val_q;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign depth        = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: table vectors, corner sequences and a random run against a queue model
module tb_stack_op_sequencer;

    localparam int SD = 256;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst, op_valid, op_ready, result_valid, error, stk_push, stk_trigger, stk_done;
    logic [3:0]  op_code;
    logic [31:0] op_imm, result, stk_write_value, stk_read_value;
    logic [1:0]  err_code;
    logic [8:0]  depth;

    always #5 clk = ~clk;

    stack_op_sequencer #(.STACK_DEPTH(SD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_imm(op_imm), .result(result), .result_valid(result_valid),
        .error(error), .err_code(err_code), .depth(depth), .stk_push(stk_push),
        .stk_trigger(stk_trigger), .stk_write_value(stk_write_value),
        .stk_read_value(stk_read_value), .stk_done(stk_done)
    );

    // Behavioural stack32: acts on each trigger, answers done after d_cyc cycles
    logic [31:0] mem [0:1023];
    int          sp = 0, trig_cnt = 0, trig_viol = 0, both_high = 0, d_cyc = 1;
    bit          withhold = 0;
    logic        busy = 1'b0, prev_trig = 1'b0;
    int          cnt = 0;
    logic [31:0] rd = '0;

    always @(posedge clk) begin
        if (stk_trigger) begin
            trig_cnt++;
            if (prev_trig) trig_viol++;
        end
        prev_trig <= stk_trigger;
        if (rst) busy <= 1'b0;
        else if (stk_trigger && !withhold) begin
            if (stk_push) begin
                mem[sp[9:0]] = stk_write_value;
                sp = sp + 1;
            end else if (sp > 0) begin
                sp = sp - 1;
                rd <= mem[sp[9:0]];
            end
            busy <= 1'b1;
            cnt  <= d_cyc - 1;
        end else if (busy) begin
            if (cnt == 0) busy <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    assign stk_done       = busy && cnt == 0;
    assign stk_read_value = rd;

    int n_tests = 0, n_fail = 0;
    int pops_t   [16] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0, 0, 0};
    int pushes_t [16] = '{1, 0, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_op_ready"}, op_ready, 1);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_depth"}, depth, 0);
        chk({tag, "_stk_push"}, stk_push, 0);
        chk({tag, "_stk_trigger"}, stk_trigger, 0);
        chk({tag, "_stk_write_value"}, stk_write_value, 0);
    endtask

    // Present one op at a negedge and wait (bounded) for its result_valid or error pulse
    task automatic issue(input logic [3:0] op, input logic [31:0] imm, input int d,
                         output int lat, output int trigs, output bit rv, output bit er);
        int t0;
        d_cyc = d;
        t0 = trig_cnt;
        op_code = op;
        op_imm = imm;
        op_valid = 1'b1;
        lat = 0;
        rv = 0;
        er = 0;
        while (lat < 300 && !rv && !er) begin
            @(negedge clk);
            op_valid = 1'b0;
            lat++;
            rv = result_valid;
            er = error;
            if (result_valid && error) both_high++;
        end
        trigs = trig_cnt - t0;
        chk("completes", longint'(rv | er), 1);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] v1,
                                            input logic [31:0] v2, input logic [31:0] imm);
        logic [63:0] prod;
        logic [31:0] all1;
        int s;
        all1 = 32'hffff_ffff;
        s = int'(v2[4:0]);
        prod = {32'd0, v1} * {32'd0, v2};
        case (op)
            4'h0: return imm;
            4'h1, 4'h2: return v2;
            4'h3: return v1 + v2;
            4'h4: return v1 - v2;
            4'h5: return prod[31:0];
            4'h6: return v1 & v2;
            4'h7: return v1 | v2;
            4'h8: return v1 ^ v2;
            4'h9: return v1 << s;
            4'hA: return (v1 >> s) | (v1[31] ? ~(all1 >> s) : 32'd0);
            4'hB: return v1 >> s;
            4'hC: return ~v2 + 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] imm;
        int          d;
        bit          err;
        logic [1:0]  code;
        logic [31:0] res;
        int          dep;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] rq[$];
    logic [31:0] last_res;

    initial begin
        int lat, tr, t0, p, q, d, exp_lat;
        bit rv, er;
        logic [3:0] op;
        logic [31:0] imm, v1, v2, r;
        logic [1:0] code;

        op_valid = 1'b0; op_code = '0; op_imm = '0;
        reset_dut();
        chk_reset("reset");

        tbl.push_back('{4'h3, 32'h0,         1, 1'b1, 2'd1, 32'h0,         0});
        tbl.push_back('{4'h0, 32'hcafe_babe, 1, 1'b0, 2'd0, 32'hcafe_babe, 1});
        tbl.push_back('{4'h1, 32'h0,         2, 1'b0, 2'd0, 32'hcafe_babe, 0});
        tbl.push_back('{4'h0, 32'h7,         1, 1'b0, 2'd0, 32'h7,         1});
        tbl.push_back('{4'h0, 32'h3,         3, 1'b0, 2'd0, 32'h3,         2});
        tbl.push_back('{4'h4, 32'h0,         1, 1'b0, 2'd0, 32'h4,         1});
        tbl.push_back('{4'h0, 32'hffff_ffff, 2, 1'b0, 2'd0, 32'hffff_ffff, 2});
        tbl.push_back('{4'h3, 32'h0,         3, 1'b0, 2'd0, 32'h3,         1});
        tbl.push_back('{4'h1, 32'h0,         1, 1'b0, 2'd0, 32'h3,         0});
        tbl.push_back('{4'h0, 32'h8000_0000, 1, 1'b0, 2'd0, 32'h8000_0000, 1});
        tbl.push_back('{4'h0, 32'h21,        2, 1'b0, 2'd0, 32'h21,        2});
        tbl.push_back('{4'hA, 32'h0,         1, 1'b0, 2'd0, 32'hc000_0000, 1});
        tbl.push_back('{4'h2, 32'h0,         2, 1'b0, 2'd0, 32'hc000_0000, 2});
        tbl.push_back('{4'hB, 32'h0,         1, 1'b0, 2'd0, 32'hc000_0000, 1});
        tbl.push_back('{4'h0, 32'h6,         1, 1'b0, 2'd0, 32'h6,         2});
        tbl.push_back('{4'h5, 32'h0,         4, 1'b0, 2'd0, 32'h8000_0000, 1});
        tbl.push_back('{4'h0, 32'h5,         1, 1'b0, 2'd0, 32'h5,         2});
        tbl.push_back('{4'hC, 32'h0,         2, 1'b0, 2'd0, 32'hffff_fffb, 2});
        tbl.push_back('{4'h1, 32'h0,         1, 1'b0, 2'd0, 32'hffff_fffb, 1});
        tbl.push_back('{4'h1, 32'h0,         1, 1'b0, 2'd0, 32'h8000_0000, 0});
        tbl.push_back('{4'hE, 32'h0,         1, 1'b1, 2'd3, 32'h8000_0000, 0});
        tbl.push_back('{4'h1, 32'h0,         1, 1'b1, 2'd1, 32'h8000_0000, 0});

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].imm, tbl[i].d, lat, tr, rv, er);
            p = pops_t[tbl[i].op];
            q = pushes_t[tbl[i].op];
            chk($sformatf("vec%0d_error", i), er, tbl[i].err);
            if (tbl[i].err) chk($sformatf("vec%0d_err_code", i), err_code, tbl[i].code);
            chk($sformatf("vec%0d_result", i), result, tbl[i].res);
            chk($sformatf("vec%0d_depth", i), depth, tbl[i].dep);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].err ? 1 : 1 + (p + q) * (1 + tbl[i].d) + 2);
            chk($sformatf("vec%0d_triggers", i), tr, tbl[i].err ? 0 : p + q);
        end

        withhold = 1;
        issue(4'h0, 32'h1234, 1, lat, tr, rv, er);
        withhold = 0;
        chk("timeout_error", er, 1);
        chk("timeout_code", err_code, 3);
        chk("timeout_depth", depth, 0);
        chk("timeout_window", longint'(lat >= TO && lat <= TO + 6), 1);
        chk("timeout_result_held", result, 32'h8000_0000);

        for (int i = 0; i < SD; i++) issue(4'h0, i, 1, lat, tr, rv, er);
        chk("fill_depth", depth, SD);
        chk("fill_result", result, SD - 1);
        issue(4'h0, 32'h77, 1, lat, tr, rv, er);
        chk("overflow_error", er, 1);
        chk("overflow_code", err_code, 2);
        chk("overflow_depth", depth, SD);
        issue(4'h2, 32'h0, 1, lat, tr, rv, er);
        chk("dup_full_error", er, 1);
        chk("dup_full_triggers", tr, 0);
        issue(4'h1, 32'h0, 2, lat, tr, rv, er);
        chk("pop_full_result", result, SD - 1);
        chk("pop_full_depth", depth, SD - 1);

        reset_dut();
        issue(4'h0, 32'd11, 1, lat, tr, rv, er);
        issue(4'h0, 32'd13, 1, lat, tr, rv, er);
        d_cyc = 6;
        t0 = trig_cnt;
        op_code = 4'h5;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 50 && trig_cnt < t0 + 2; i++) @(negedge clk);
        chk("mul_reached_pop_a", trig_cnt - t0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midop");
        issue(4'h0, 32'hdead_beef, 2, lat, tr, rv, er);
        issue(4'h1, 32'h0, 2, lat, tr, rv, er);
        chk("after_reset_pop", result, 32'hdead_beef);
        chk("after_reset_depth", depth, 0);

        reset_dut();
        last_res = '0;
        rq.delete();
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(0, 15));
            imm = $urandom;
            d = $urandom_range(1, 4);
            p = pops_t[op];
            q = pushes_t[op];
            if (op > 4'hC) code = 2'd3;
            else if (rq.size() < p) code = 2'd1;
            else if (rq.size() - p + q > SD) code = 2'd2;
            else code = 2'd0;
            issue(op, imm, d, lat, tr, rv, er);
            if (code == 2'd0) begin
                v2 = (p > 0) ? rq.pop_back() : 32'd0;
                v1 = (p > 1) ? rq.pop_back() : 32'd0;
                r = ref_alu(op, v1, v2, imm);
                for (int k = 0; k < q; k++) rq.push_back(r);
                last_res = r;
                exp_lat = 1 + (p + q) * (1 + d) + 2;
            end else exp_lat = 1;
            chk($sformatf("rnd%0d_op%0h_error", n, op), er, code != 2'd0);
            if (code != 2'd0) chk($sformatf("rnd%0d_err_code", n), err_code, code);
            chk($sformatf("rnd%0d_op%0h_result", n, op), result, last_res);
            chk($sformatf("rnd%0d_depth", n), depth, rq.size());
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
        end

        chk("single_cycle_triggers", trig_viol, 0);
        chk("error_and_valid_exclusive", both_high, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
